// File: rtl/comp_seq16.sv
// rtl/comp_seq16.sv - multi-cycle MSB-first sliced magnitude comparator with start/done handshake
// Define COMP_SIGNED_EN to compare two's-complement operands (MSB slice signed).
module comp_seq16 #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             valid,
   output logic             gt,
   output logic             eq
);

   localparam int NSL = WIDTH / SLICE;
   localparam int IW  = (NSL > 1) ? $clog2(NSL) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(NSL - 1);

   typedef enum logic {IDLE, CMP} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] ra_q, ra_d, rb_q, rb_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             done_q, done_d;
   logic             valid_q, valid_d;
   logic             gt_q, gt_d;
   logic             eq_q, eq_d;

   logic [SLICE-1:0] sa, sb;
   logic             slice_gt, slice_lt;

   assign sa = ra_q[idx_q*SLICE +: SLICE];
   assign sb = rb_q[idx_q*SLICE +: SLICE];

   always_comb begin
      slice_gt = 1'b0;
      slice_lt = 1'b0;
`ifdef COMP_SIGNED_EN
      // Only the top slice carries the sign; lower slices are plain magnitude digits.
      if (idx_q == IDX_LAST) begin
         slice_gt = $signed(sa) > $signed(sb);
         slice_lt = $signed(sa) < $signed(sb);
      end else begin
         slice_gt = sa > sb;
         slice_lt = sa < sb;
      end
`else
      slice_gt = sa > sb;
      slice_lt = sa < sb;
`endif
   end

   always_comb begin
      state_d = state_q;
      ra_d    = ra_q;
      rb_d    = rb_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
      valid_d = valid_q;
      gt_d    = gt_q;
      eq_d    = eq_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               ra_d    = a;
               rb_d    = b;
               idx_d   = IDX_LAST;
               valid_d = 1'b0;
               gt_d    = 1'b0;
               eq_d    = 1'b0;
               state_d = CMP;
            end
         end
         CMP: begin
            if (slice_gt || slice_lt) begin
               gt_d    = slice_gt;
               eq_d    = 1'b0;
               done_d  = 1'b1;
               valid_d = 1'b1;
               state_d = IDLE;
            end else if (idx_q == '0) begin
               gt_d    = 1'b0;
               eq_d    = 1'b1;
               done_d  = 1'b1;
               valid_d = 1'b1;
               state_d = IDLE;
            end else begin
               idx_d = idx_q - IW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ra_q    <= '0;
         rb_q    <= '0;
         idx_q   <= IDX_LAST;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         gt_q    <= 1'b0;
         eq_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ra_q    <= ra_d;
         rb_q    <= rb_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
         valid_q <= valid_d;
         gt_q    <= gt_d;
         eq_q    <= eq_d;
      end
   end

   assign busy  = (state_q == CMP);
   assign done  = done_q;
   assign valid = valid_q;
   assign gt    = gt_q;
   assign eq    = eq_q;

endmodule

// File: tb/tb_comp_seq16.sv
// tb/tb_comp_seq16.sv - directed self-checking bench for comp_seq16
module tb_comp_seq16;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] a, b;
   logic        busy, done, valid, gt, eq;

   int n_checks = 0;
   int n_pass   = 0;
   int done_cnt = 0;
   int n;

   comp_seq16 #(.WIDTH(16), .SLICE(4)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .valid(valid), .gt(gt), .eq(eq)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
      if (done) done_cnt++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // exp_n = clock edges from the accepting edge to done (done in cycle E+1+exp_n)
   task automatic run_cmp(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                          input int exp_n, input logic egt, input logic eeq);
      a = ta; b = tb; start = 1'b1;
      step();
      start = 1'b0;
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_valid_clr"}, valid, 0);
      n = 0;
      while (!done && n < 20) begin
         step();
         n++;
      end
      chk({tag, "_lat"}, n, exp_n);
      chk({tag, "_gt"}, gt, egt);
      chk({tag, "_eq"}, eq, eeq);
      chk({tag, "_valid"}, valid, 1);
      step();
      chk({tag, "_done_pulse"}, done, 0);
      chk({tag, "_hold_gt"}, gt, egt);
      chk({tag, "_hold_valid"}, valid, 1);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; a = '0; b = '0;
      step(); step();
      rst = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_valid", valid, 0);
      chk("rst_gt", gt, 0);
      chk("rst_eq", eq, 0);

      // T1: reset mid-compare, no done
      done_cnt = 0;
      a = 16'h1234; b = 16'h1235; start = 1'b1;
      step();
      start = 1'b0;
      step();
      rst = 1'b1;
      step();
      chk("t1_busy", busy, 0);
      chk("t1_valid", valid, 0);
      chk("t1_gt", gt, 0);
      chk("t1_eq", eq, 0);
      step(); step();
      rst = 1'b0;
      step(); step(); step(); step();
      chk("t1_no_done", done_cnt, 0);
      chk("t1_idle", busy, 0);

      // T2: MSB-slice decides
`ifdef COMP_SIGNED_EN
      run_cmp("t2", 16'h8000, 16'h7FFF, 1, 1'b0, 1'b0);
`else
      run_cmp("t2", 16'h8000, 16'h7FFF, 1, 1'b1, 1'b0);
`endif
      // T3: equal operands, full latency
      run_cmp("t3", 16'hA5A5, 16'hA5A5, 4, 1'b0, 1'b1);
      // T4: LSB and third-slice differences
      run_cmp("t4a", 16'h1230, 16'h1231, 4, 1'b0, 1'b0);
      run_cmp("t4b", 16'h1240, 16'h1231, 3, 1'b1, 1'b0);
      run_cmp("t4c", 16'h0000, 16'h0000, 4, 1'b0, 1'b1);

      // T5: start while busy is ignored
      done_cnt = 0;
      a = 16'h1230; b = 16'h1231; start = 1'b1;
      step();
      start = 1'b0;
      step();
      a = 16'hFFFF; b = 16'h0000; start = 1'b1;
      step();
      start = 1'b0;
      n = 2;
      while (!done && n < 20) begin
         step();
         n++;
      end
      chk("t5_lat", n, 4);
      chk("t5_gt", gt, 0);
      chk("t5_eq", eq, 0);
      step(); step(); step();
      chk("t5_one_done", done_cnt, 1);
      chk("t5_idle", busy, 0);

      // T6: start held high, back-to-back compares
      a = 16'hFFFF; b = 16'h0000; start = 1'b1;
      step();
      for (int i = 0; i < 6; i++) begin
         step();
         chk($sformatf("t6_done_%0d", i), done, (i % 2 == 0));
         chk($sformatf("t6_valid_%0d", i), valid, (i % 2 == 0));
         chk($sformatf("t6_busy_%0d", i), busy, (i % 2 == 1));
         if (i % 2 == 0) chk($sformatf("t6_gt_%0d", i), gt, 1);
      end
      start = 1'b0;
      step(); step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
